// File: rtl/uart_pkg.sv
// Shared UART definitions for the byte transmitter and the future byte receiver.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_tx_state_t;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the grid assembler (master) and the UART transmitter (slave).
interface uart_byte_tx_if;
  import uart_pkg::*;

  logic                 send;
  logic [DATA_BITS-1:0] byte_in;
  logic                 busy;
  logic                 transmit_done;

  modport master (
    output send,
    output byte_in,
    input  busy,
    input  transmit_done
  );

  modport slave (
    input  send,
    input  byte_in,
    output busy,
    output transmit_done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared and ticks on the last count.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Wrapping at the terminal count keeps the counter inside CNT_W bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clear && (count == LAST_COUNT);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter, 8N1 LSB first, idle-high registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_tx_if.slave  bus,
  output logic           tx
);

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 timer_clear;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // The timer only runs while a frame is on the line, so each frame starts at count 0.
  assign timer_clear = (state == IDLE) || (state == DONE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      tx                 <= 1'b1;
      bus.busy           <= 1'b0;
      bus.transmit_done  <= 1'b0;
      shift              <= '0;
      bit_idx            <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit         <= 1'b0;
`endif
    end else begin
      bus.transmit_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (bus.send) begin
            shift    <= bus.byte_in;
            bit_idx  <= '0;
            tx       <= 1'b0;
            bus.busy <= 1'b1;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^bus.byte_in;
`endif
          end
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        // tx is loaded with the next bit at the boundary so the pin never waits on the shift.
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            bus.busy          <= 1'b0;
            bus.transmit_done <= 1'b1;
            state             <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          tx       <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: stimulus queues expected bytes, a line monitor decodes tx.
module tb_uart_byte_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int DONE_CYC = NBITS * CPB + 1;

  logic clk;
  logic rst;
  logic tx;

  int checks;
  int failures;
  int exp_done;
  int done_seen;
  logic [7:0] exp_q[$];

  uart_byte_tx_if bus ();

  uart_byte_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Waits for the DUT to be back in IDLE; an expired budget counts as a failure.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((bus.busy !== 1'b0 || bus.transmit_done !== 1'b0) && n < 200);
    check_output("wait_idle_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Issues one send pulse; expect_frame=0 for a frame that will be aborted by reset.
  task automatic apply_stimulus(input logic [7:0] b, input bit expect_frame);
    @(posedge clk);
    #1;
    bus.send    = 1'b1;
    bus.byte_in = b;
    if (expect_frame) begin
      exp_q.push_back(b);
      exp_done++;
    end
    @(posedge clk);
    #1;
    check_output("tx_fall_latency", {31'd0, tx}, 32'd0);
    check_output("busy_after_capture", {31'd0, bus.busy}, 32'd1);
    bus.send    = 1'b0;
    bus.byte_in = ~b;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.transmit_done === 1'b1) done_seen++;
  end

  // Line monitor: decodes frames from tx and compares them against the scoreboard.
  initial begin
    int c;
    bit aborted;
    logic [NBITS-1:0] bits;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 || tx !== 1'b0) continue;
      c       = 1;
      aborted = 1'b0;
      bits    = '0;
      while (c < DONE_CYC) begin
        @(negedge clk);
        c++;
        if (rst !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (((c - (CPB / 2 + 1)) % CPB) == 0 && ((c - (CPB / 2 + 1)) / CPB) < NBITS)
          bits[(c - (CPB / 2 + 1)) / CPB] = tx;
        if (c == DONE_CYC - 1)
          check_output("done_early", {31'd0, bus.transmit_done}, 32'd0);
      end
      if (!aborted) begin
        check_output("done_timing", {31'd0, bus.transmit_done}, 32'd1);
        check_output("busy_in_done", {31'd0, bus.busy}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_frame actual=%0h required=none at %0t", bits[8:1], $time);
        end else begin
          exp_b = exp_q.pop_front();
          check_output("start_bit", {31'd0, bits[0]}, 32'd0);
          check_output("data_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
`ifdef UART_TX_PARITY_EN
          check_output("parity_bit", {31'd0, bits[9]}, {31'd0, ^exp_b});
`endif
          check_output("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    exp_done    = 0;
    done_seen   = 0;
    rst         = 1'b0;
    bus.send    = 1'b0;
    bus.byte_in = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_tx", {31'd0, tx}, 32'd1);
    check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_output("reset_done", {31'd0, bus.transmit_done}, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("post_reset_tx", {31'd0, tx}, 32'd1);
    check_output("post_reset_busy", {31'd0, bus.busy}, 32'd0);
    check_output("post_reset_done", {31'd0, bus.transmit_done}, 32'd0);

    // Single byte
    apply_stimulus(8'hA5, 1'b1);
    wait_idle();

    // Back-to-back: send held from the DONE cycle into the following IDLE cycle
    apply_stimulus(8'h03, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.transmit_done !== 1'b1 && n < 200);
    check_output("b2b_done_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    bus.send    = 1'b1;
    bus.byte_in = 8'hFF;
    exp_q.push_back(8'hFF);
    exp_done++;
    @(posedge clk);
    #1;
    check_output("b2b_ignored_in_done", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    check_output("b2b_second_start", {31'd0, tx}, 32'd0);
    bus.send = 1'b0;
    wait_idle();

    // Request during DATA is ignored
    apply_stimulus(8'h55, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    bus.send    = 1'b1;
    bus.byte_in = 8'h00;
    @(posedge clk);
    #1;
    bus.send = 1'b0;
    wait_idle();
    repeat (50) @(posedge clk);
    #1;
    check_output("no_extra_frame", {31'd0, tx}, 32'd1);

    // Reset during data bit 3 of 8'h0F
    apply_stimulus(8'h0F, 1'b0);
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_output("abort_tx_high", {31'd0, tx}, 32'd1);
    check_output("abort_busy_low", {31'd0, bus.busy}, 32'd0);
    check_output("abort_no_done", {31'd0, bus.transmit_done}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    apply_stimulus(8'h81, 1'b1);
    wait_idle();

    // Parity vectors (odd and even number of ones)
    apply_stimulus(8'h07, 1'b1);
    wait_idle();
    apply_stimulus(8'h03, 1'b1);
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    check_output("scoreboard_empty", exp_q.size(), 32'd0);
    check_output("done_pulse_count", done_seen, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Serialises one byte at a time onto a UART TX line for the solved-grid output path.
- Consumes the assembler's send/byte_out strobe and returns a transmit_done pulse when the byte has fully left the pin.
- Sits between the assembler and the top-level FPGA TX pin. Format is 8N1, LSB first, idle-high line.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset. Asserting low resets immediately; deassertion is synchronous to clk upstream.
- send  input  1  request strobe; byte_in is captured on the cycle send=1 while idle.
- byte_in  input  8  byte to transmit (driven by assembler byte_out).
- tx  output  1  serial line, idle high.
- busy  output  1  high from the cycle after capture through the last stop-bit cycle.
- transmit_done  output  1  single-cycle pulse after the stop bit completes.

Behaviour:
- Reset (rst=0): state IDLE, tx=1, busy=0, transmit_done=0, shift register=0, bit counter=0, clock counter=0.
- FSM states:
  - IDLE: tx=1. On send=1, latch byte_in into shift register, clear counters, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]. Each CLKS_PER_BIT cycles, shift right and increment bit index. After bit index 7 completes, go to STOP (PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then DONE.
  - DONE: transmit_done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: tx falls on the cycle after send is sampled. Total frame is 10*CLKS_PER_BIT cycles; transmit_done asserts at cycle 10*CLKS_PER_BIT+1 after capture.
- Clock counter counts 0..CLKS_PER_BIT-1 and wraps. The bit boundary is at count==CLKS_PER_BIT-1. Counter is CNT_W bits with no overflow beyond the terminal count.
- send while busy=1 or in DONE: ignored. No queueing, no corruption of the in-flight byte.
- send held high across multiple cycles: only one capture. A new capture needs send=1 while in IDLE, so send still high on the cycle after DONE starts a new frame.
- byte_in changes after capture: no effect on the frame.
- Reset mid-frame: tx returns high immediately (async) and no transmit_done is issued for the aborted byte.
- tx is registered, so there are no combinational glitches on the pin.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11 bit periods and transmit_done moves to 11*CLKS_PER_BIT+1.
- Undefined: no PARITY state, no parity logic, 8N1 frame exactly as above.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP, DONE};
  - localparam DATA_BITS=8;
  - localparam DEFAULT_CLKS_PER_BIT=868.
  - The package is shared with a future uart_byte_rx.
- One sub-module, uart_bit_timer. It takes clk, rst, clear and tick, owns the CLKS_PER_BIT counter, and emits a one-cycle tick at each bit boundary. The FSM stays in uart_byte_tx.

Test Plan:
- Reset check (CLKS_PER_BIT=4): hold rst=0 for 3 cycles -> tx=1, busy=0, transmit_done=0. Release -> still idle, no pulse.
- Single byte 8'hA5, CLKS_PER_BIT=4: pulse send one cycle -> tx sequence start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles. transmit_done pulses once at cycle 41 after capture.
- Back-to-back: send 8'h03, then assert send on the transmit_done cycle with 8'hFF -> second frame starts on the next cycle, both decoded correctly by a bench UART monitor.
- Ignored request: send 8'h55, then pulse send with 8'h00 mid-DATA -> line still carries 8'h55, exactly one transmit_done.
- Mid-frame reset: drop rst during bit 3 of 8'h0F -> tx=1 the same cycle, no transmit_done. After release, sending 8'h81 transmits cleanly.
- With UART_TX_PARITY_EN: send 8'h07 -> parity bit 1, stop bit after it, transmit_done at cycle 45. Send 8'h03 -> parity bit 0.
